// File: rtl/pc_sequencer_pkg.sv
// Shared constants and types for the fetch sequencer.
package pc_sequencer_pkg;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // Resolved redirect: the PC actually loaded and whether it is a misalignment trap.
    typedef struct packed {
        logic [31:0] pc;
        logic        trap;
    } redir_t;

endpackage

// File: rtl/pc_sequencer_incrementer.sv
// Combinational sequential-PC adder, shared with the branch unit.
module pc_incrementer
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_INC;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter fetch sequencer between imem (req/ack) and decode (valid/ready).
// Optional feature: PC_ALIGN_CHECK_EN traps misaligned redirect targets to EXC_VECTOR.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_out,
    output logic        misalign_exc
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        pend_q, pend_d;
    redir_t      ptgt_q, ptgt_d;
    logic        gap_q, gap_d;
    logic        exc_q, exc_d;
    redir_t      redir_in;
    logic [31:0] pc_inc;

    pc_incrementer u_inc (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc)
    );

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        redir_in.trap = |redirect_target[1:0];
        redir_in.pc   = redir_in.trap ? EXC_VECTOR : redirect_target;
    end
`else
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
    always_comb begin
        redir_in.trap = 1'b0;
        redir_in.pc   = redirect_target & ~32'h3;
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        gap_d   = 1'b0;
        exc_d   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (gap_q) begin
                    // No transaction outstanding during the gap: redirect loads directly.
                    if (redirect_valid) begin
                        pc_d  = redir_in.pc;
                        exc_d = redir_in.trap;
                    end
                end else if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_d   = redir_in.pc;
                        exc_d  = redir_in.trap;
                        gap_d  = 1'b1;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = ptgt_q.pc;
                        exc_d  = ptgt_q.trap;
                        gap_d  = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pend_d = 1'b1;
                    ptgt_d = redir_in;
                end
            end
            S_HOLD: begin
                valid_d = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redir_in.pc;
                    exc_d   = redir_in.trap;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (instr_ready && !stall) begin
                    pc_d    = pc_inc;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= WORD_ZERO;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            ptgt_q  <= '0;
            gap_q   <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
            gap_q   <= gap_d;
            exc_q   <= exc_d;
        end
    end

    assign imem_req     = (state_q == S_FETCH) && !gap_q;
    assign imem_addr    = pc_q;
    assign pc_out       = pc_q;
    assign instr_out    = instr_q;
    assign instr_valid  = valid_q;
    assign misalign_exc = exc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer; reset vector set near the top of memory.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'hFFFF_FFFC;
    localparam logic [31:0] EV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req, instr_valid, misalign_exc;
    logic [31:0] imem_addr, instr_out, pc_out;

    pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc_out(pc_out), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ins_t;
    logic [31:0] fetch_q[$];
    ins_t        instr_q[$];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic resolve(input logic [31:0] t, output logic [31:0] npc, output logic trap);
`ifdef PC_ALIGN_CHECK_EN
        trap = (t[1:0] != 2'b00);
        npc  = trap ? EV : t;
`else
        trap = 1'b0;
        npc  = {t[31:2], 2'b00};
`endif
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] tbl [5] = '{32'h100, 32'h103, 32'h200, 32'h40, 32'hFFFF_FFFC};
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Monitor: pops expectations whenever the DUT starts a fetch or presents an instruction.
    bit          txn_open = 0;
    bit          hold_open = 0;
    logic [31:0] open_addr = '0;
    ins_t        cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            txn_open  = 0;
            hold_open = 0;
        end else begin
            if (imem_ack && txn_open) txn_open = 0;
            if (imem_req) begin
                if (!txn_open) begin
                    if (fetch_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                    end else begin
                        chk("fetch_addr", imem_addr, fetch_q.pop_front());
                    end
                    txn_open  = 1;
                    open_addr = imem_addr;
                end else begin
                    chk("addr_stable", imem_addr, open_addr);
                end
            end
            if (instr_valid) begin
                if (!hold_open) begin
                    if (instr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_valid: got pc %h expected no instruction", pc_out);
                        cur = '{pc: pc_out, ins: instr_out};
                    end else begin
                        cur = instr_q.pop_front();
                    end
                    hold_open = 1;
                end
                chk("instr_out", instr_out, cur.ins);
                chk("pc_out", pc_out, cur.pc);
                chk("req_in_hold", {31'b0, imem_req}, 32'd0);
            end else begin
                hold_open = 0;
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            cyc();
            n++;
        end
        if (!imem_req) begin
            total++; bad++;
            $display("FAIL req_timeout: got imem_req 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic one_iter();
        logic [31:0] t, npc, data;
        logic        trap, ptrap, redirected;
        int          d, s;
        wait_req();
        if (!imem_req) return;
        d = $urandom_range(0, 3);
        redirected = 0;
        ptrap = 0;
        npc = '0;
        for (int k = 0; k <= d; k++) begin
            imem_ack   = (k == d);
            data       = $urandom;
            imem_rdata = data;
            redirect_valid = ($urandom_range(0, 3) == 0);
            if (redirect_valid) begin
                t = pick_target();
                redirect_target = t;
                resolve(t, npc, ptrap);
                redirected = 1;
            end
            if (k == d) begin
                if (redirected) begin
                    m_pc = npc;
                    fetch_q.push_back(npc);
                end else begin
                    instr_q.push_back('{pc: m_pc, ins: data});
                end
            end
            cyc();
            imem_ack = 0;
            redirect_valid = 0;
            if (k < d) chk("req_held", {31'b0, imem_req}, 32'd1);
        end
        if (redirected) begin
            chk("drop_no_valid", {31'b0, instr_valid}, 32'd0);
            chk("drop_gap_req", {31'b0, imem_req}, 32'd0);
            chk("exc_at_load", {31'b0, misalign_exc}, {31'b0, ptrap});
            cyc();
            chk("req_after_drop", {31'b0, imem_req}, 32'd1);
            chk("exc_one_cycle", {31'b0, misalign_exc}, 32'd0);
        end else begin
            chk("valid_after_ack", {31'b0, instr_valid}, 32'd1);
            s = $urandom_range(0, 3);
            for (int j = 0; j < s; j++) begin
                instr_ready = $urandom_range(0, 1);
                stall = instr_ready ? 1'b1 : 1'($urandom_range(0, 1));
                cyc();
                chk("held_valid", {31'b0, instr_valid}, 32'd1);
                chk("no_req_held", {31'b0, imem_req}, 32'd0);
            end
            if ($urandom_range(0, 3) == 0) begin
                t = pick_target();
                redirect_valid  = 1;
                redirect_target = t;
                instr_ready = $urandom_range(0, 1);
                stall = $urandom_range(0, 1);
                resolve(t, npc, trap);
                m_pc = npc;
            end else begin
                instr_ready = 1;
                stall = 0;
                m_pc = m_pc + 32'd4;
                trap = 0;
            end
            fetch_q.push_back(m_pc);
            cyc();
            redirect_valid = 0;
            instr_ready = 0;
            stall = 0;
            chk("valid_cleared", {31'b0, instr_valid}, 32'd0);
            chk("req_next", {31'b0, imem_req}, 32'd1);
            chk("exc_hold", {31'b0, misalign_exc}, {31'b0, trap});
        end
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc_out, RV);
        chk("rst_exc", {31'b0, misalign_exc}, 32'd0);
        m_pc = RV;
        fetch_q.push_back(RV);
        rst_n = 1;
        cyc();
        chk("req_after_release", {31'b0, imem_req}, 32'd1);
        repeat (200) one_iter();

        // Reset in the middle of a fetch, with a late ack around the release.
        wait_req();
        rst_n = 0;
        cyc();
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst_pc", pc_out, RV);
        imem_ack = 1;
        cyc();
        m_pc = RV;
        fetch_q.push_back(RV);
        rst_n = 1;
        cyc();
        imem_ack = 0;
        chk("late_ack_ignored_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_ack_req", {31'b0, imem_req}, 32'd1);
        repeat (60) one_iter();

        chk("fetch_q_empty", fetch_q.size(), 32'd0);
        chk("instr_q_empty", instr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1, "watchdog");
    end

endmodule
